// File: rtl/rpm_mult_seq.sv
// Iterative shift-and-add (Russian-peasant) multiplier with valid/ready handshakes.
// One multiplier bit per clock; the run ends as soon as the remaining multiplier bits are zero.
module rpm_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     iter_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ACC_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_n;
    logic [2*WIDTH-1:0]   mc_r;
    logic [WIDTH-1:0]     mr_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   product_r;
    logic [CNT_W-1:0]     iter_cnt_r;
    logic [WIDTH-1:0]     mr_shift_s;
    logic [2*WIDTH-1:0]   acc_add_s;

    // The most negative input maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        if (s && v[WIDTH-1]) begin
            magnitude = ~v + W_ONE;
        end else begin
            magnitude = v;
        end
    endfunction

    assign mr_shift_s = mr_r >> 1;
    assign acc_add_s  = mr_r[0] ? (acc_r + mc_r) : acc_r;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;
    assign iter_cnt  = iter_cnt_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; DONE waits for its own registered out_valid before honouring out_ready.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (mr_shift_s == {WIDTH{1'b0}}) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_r        <= {(2*WIDTH){1'b0}};
            mr_r        <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            neg_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            product_r   <= {(2*WIDTH){1'b0}};
            iter_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mc_r       <= {{WIDTH{1'b0}}, magnitude(a, is_signed)};
                        mr_r       <= magnitude(b, is_signed);
                        acc_r      <= {(2*WIDTH){1'b0}};
                        neg_r      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r <= acc_add_s;
                    mc_r  <= mc_r << 1;
                    mr_r  <= mr_shift_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end
                DONE: begin
                    if (!out_valid_r) begin
                        product_r   <= neg_r ? (~acc_r + ACC_ONE) : acc_r;
                        iter_cnt_r  <= cnt_r;
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpm_mult_seq.sv
// Self-checking bench for rpm_mult_seq at WIDTH=8 and WIDTH=16 against an integer reference multiply.
module tb_rpm_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv8 = 1'b0;
    logic        iv16 = 1'b0;
    logic [15:0] a_bus = 16'h0;
    logic [15:0] b_bus = 16'h0;
    logic        is_signed = 1'b0;
    logic        out_ready = 1'b0;
    logic        rdy8, rdy16, ov8, ov16;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;
    int          checks = 0;
    int          errors = 0;

    rpm_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .is_signed(is_signed),
        .out_valid(ov8), .out_ready(out_ready), .product(prod8), .iter_cnt(cnt8)
    );

    rpm_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
        .a(a_bus), .b(b_bus), .is_signed(is_signed),
        .out_valid(ov16), .out_ready(out_ready), .product(prod16), .iter_cnt(cnt16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_prod(input bit sel);
        return sel ? prod16 : {16'h0, prod8};
    endfunction

    function automatic logic [31:0] obs_cnt(input bit sel);
        return sel ? {27'h0, cnt16} : {28'h0, cnt8};
    endfunction

    function automatic logic obs_ov(input bit sel);
        return sel ? ov16 : ov8;
    endfunction

    function automatic logic obs_rdy(input bit sel);
        return sel ? rdy16 : rdy8;
    endfunction

    // One full operation: accept, scramble inputs, wait for result, optional backpressure, handshake.
    task automatic do_op(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                         input logic sg, input int hold);
        int w, n, k;
        longint sa, sb, mb, pr;
        longint unsigned mask, pmask, exp_p;
        logic [31:0] held_p, held_c;
        w     = sel ? 16 : 8;
        mask  = (64'd1 << w) - 64'd1;
        pmask = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'({48'h0, av}) & longint'(mask);
        sb = longint'({48'h0, bv}) & longint'(mask);
        if (sg && sa >= (64'sd1 << (w - 1))) sa = sa - (64'sd1 << w);
        if (sg && sb >= (64'sd1 << (w - 1))) sb = sb - (64'sd1 << w);
        mb = (sb < 0) ? -sb : sb;
        n = 0;
        while (mb > 0) begin
            n++;
            mb = mb >> 1;
        end
        if (n == 0) n = 1;
        pr    = sa * sb;
        exp_p = longint'(pr) & pmask;

        a_bus = av;
        b_bus = bv;
        is_signed = sg;
        if (sel) iv16 = 1'b1; else iv8 = 1'b1;
        check("accept_ready", {31'h0, obs_rdy(sel)}, 32'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        iv16 = 1'b0;
        a_bus = 16'($urandom);
        b_bus = 16'($urandom);
        is_signed = 1'($urandom);
        k = 0;
        while (!obs_ov(sel) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, n + 1);
        check("product", obs_prod(sel), exp_p[31:0]);
        check("iter_cnt", obs_cnt(sel), n);
        held_p = obs_prod(sel);
        held_c = obs_cnt(sel);
        for (int i = 0; i < hold; i++) begin
            if (sel) iv16 = 1'b1; else iv8 = 1'b1;
            a_bus = 16'($urandom);
            @(posedge clk); #1;
            check("bp_valid", {31'h0, obs_ov(sel)}, 32'd1);
            check("bp_product", obs_prod(sel), held_p);
            check("bp_iter_cnt", obs_cnt(sel), held_c);
            check("bp_ready", {31'h0, obs_rdy(sel)}, 32'd0);
        end
        iv8 = 1'b0;
        iv16 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", {31'h0, obs_ov(sel)}, 32'd0);
        check("drain_ready", {31'h0, obs_rdy(sel)}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready8", {31'h0, rdy8}, 32'd1);
        check("rst_valid8", {31'h0, ov8}, 32'd0);
        check("rst_prod8", {16'h0, prod8}, 32'd0);
        check("rst_cnt8", {28'h0, cnt8}, 32'd0);
        check("rst_ready16", {31'h0, rdy16}, 32'd1);
        check("rst_prod16", prod16, 32'd0);

        do_op(1'b0, 16'd13,   16'd11,   1'b0, 0);
        do_op(1'b0, 16'd255,  16'd255,  1'b0, 0);
        do_op(1'b0, 16'd200,  16'd0,    1'b0, 0);
        do_op(1'b0, 16'h00F9, 16'd6,    1'b1, 0);
        do_op(1'b0, 16'h0080, 16'h0080, 1'b1, 0);
        do_op(1'b0, 16'h007F, 16'h00FF, 1'b1, 5);
        do_op(1'b1, 16'h8000, 16'h8000, 1'b1, 2);
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 0);

        // Reset during the second RUN cycle discards the operation.
        a_bus = 16'd100;
        b_bus = 16'd200;
        is_signed = 1'b0;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", {31'h0, ov8}, 32'd0);
        check("midrst_prod", {16'h0, prod8}, 32'd0);
        check("midrst_ready", {31'h0, rdy8}, 32'd1);
        do_op(1'b0, 16'd3, 16'd5, 1'b0, 0);

        for (int i = 0; i < 1500; i++) begin
            do_op(1'b0, 16'($urandom), 16'($urandom >> $urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        for (int i = 0; i < 1500; i++) begin
            do_op(1'b1, 16'($urandom), 16'($urandom >> $urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
